// File: rtl/data_proc_pipe.sv
// rtl/data_proc_pipe.sv - two-stage valid/ready signed ALU with persistent accumulator
// Optional clamp-on-overflow accumulator selected by `define DATA_PROC_SAT_EN.
module data_proc_pipe #(
  parameter int W     = 8,
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  input  logic        [2:0]       op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] c,
  output logic                    sat
);

  logic                    s1_full;
  logic signed [W-1:0]     s1_a;
  logic signed [W-1:0]     s1_b;
  logic        [2:0]       s1_op;
  logic signed [ACC_W-1:0] acc;

  logic s2_load;
  logic s1_adv;
  logic in_fire;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_full && s2_load;
  assign in_ready = !s1_full || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // Operands widened to ACC_W so add/sub are exact (ACC_W >= W+1).
  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] res_c;
  logic                    res_sat;
  logic signed [ACC_W-1:0] acc_nxt;

  assign a_ext = {{(ACC_W-W){s1_a[W-1]}}, s1_a};
  assign b_ext = {{(ACC_W-W){s1_b[W-1]}}, s1_b};

`ifdef DATA_PROC_SAT_EN
  logic signed [ACC_W:0] acc_sum;
  assign acc_sum = {acc[ACC_W-1], acc} + {a_ext[ACC_W-1], a_ext};
`endif

  always_comb begin
    res_c   = '0;
    res_sat = 1'b0;
    acc_nxt = acc;
    case (s1_op)
      3'd0: res_c = a_ext;
      3'd1: res_c = b_ext;
      3'd2: res_c = a_ext + b_ext;
      3'd3: res_c = a_ext - b_ext;
      3'd4: begin
`ifdef DATA_PROC_SAT_EN
        // Disagreeing top two bits of the widened sum means it left the ACC_W range.
        if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
          acc_nxt = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          res_sat = 1'b1;
        end else begin
          acc_nxt = acc_sum[ACC_W-1:0];
        end
`else
        acc_nxt = acc + a_ext;
`endif
        res_c = acc_nxt;
      end
      3'd5: begin
        acc_nxt = '0;
        res_c   = '0;
      end
      3'd6: res_c = (s1_a > s1_b) ? a_ext : b_ext;
      3'd7: res_c = (s1_a < s1_b) ? a_ext : b_ext;
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_op   <= '0;
    end else begin
      if (in_fire) begin
        s1_full <= 1'b1;
        s1_a    <= a;
        s1_b    <= b;
        s1_op   <= op;
      end else if (s1_adv) begin
        s1_full <= 1'b0;
      end
    end
  end

  // acc only moves when a beat actually lands in S2, so stalls never re-apply it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      acc       <= '0;
    end else if (s2_load) begin
      out_valid <= s1_full;
      if (s1_full) begin
        c   <= res_c;
        acc <= acc_nxt;
      end
    end
  end

`ifdef DATA_PROC_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if (s2_load && s1_full) begin
      sat <= res_sat;
    end
  end
`else
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_data_proc_pipe.sv
// tb/tb_data_proc_pipe.sv - randomized and directed checks of data_proc_pipe against a queue-based model
module tb_data_proc_pipe;

  localparam int W     = 8;
  localparam int ACC_W = 12;
  localparam int ACC_MAX = 2047;
  localparam int ACC_MIN = -2048;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     a;
  logic signed [W-1:0]     b;
  logic        [2:0]       op;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] c;
  logic                    sat;

  data_proc_pipe #(.W(W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int model_acc = 0;
  int exp_c_q[$];
  int exp_s_q[$];
  int out_count = 0;
  bit stall_prev = 0;
  int held_c = 0;
  bit saw_not_ready = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wrap_acc(input int v);
    int m;
    m = v & 32'h0fff;
    return (m >= 2048) ? m - 4096 : m;
  endfunction

  // Reference: evaluates the opcode rules directly in integers, acc applied in accept order.
  task automatic model_push(input int ma, input int mb, input int mop);
    int r;
    int s;
    int sum;
    s = 0;
    case (mop)
      0: r = ma;
      1: r = mb;
      2: r = ma + mb;
      3: r = ma - mb;
      4: begin
        sum = model_acc + ma;
`ifdef DATA_PROC_SAT_EN
        if (sum > ACC_MAX) begin sum = ACC_MAX; s = 1; end
        else if (sum < ACC_MIN) begin sum = ACC_MIN; s = 1; end
`else
        sum = wrap_acc(sum);
`endif
        model_acc = sum;
        r = sum;
      end
      5: begin model_acc = 0; r = 0; end
      6: r = (ma > mb) ? ma : mb;
      default: r = (ma < mb) ? ma : mb;
    endcase
    exp_c_q.push_back(r);
    exp_s_q.push_back(s);
  endtask

  // One clock: called at a negedge, drives, samples, predicts this edge's transfers.
  task automatic cycle(input bit iv, input int ia, input int ib, input int iop,
                       input bit ordy, output bit accepted);
    int ec;
    int es;
    in_valid  = iv;
    a         = ia[W-1:0];
    b         = ib[W-1:0];
    op        = iop[2:0];
    out_ready = ordy;
    #1;
    if (!in_ready) saw_not_ready = 1;
    if (out_valid && stall_prev) chk("hold_c", int'(c), held_c);
    if (out_valid && out_ready) begin
      if (exp_c_q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        ec = exp_c_q.pop_front();
        es = exp_s_q.pop_front();
        chk("c", int'(c), ec);
        chk("sat", int'(sat), es);
        out_count++;
      end
    end
    stall_prev = out_valid && !out_ready;
    held_c     = int'(c);
    accepted   = iv && in_ready;
    if (accepted) model_push(ia, ib, iop);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int sa, input int sb, input int sop);
    bit acc_ok;
    int n;
    acc_ok = 0;
    n = 0;
    while (!acc_ok && n < 50) begin
      cycle(1'b1, sa, sb, sop, 1'b1, acc_ok);
      n++;
    end
    if (!acc_ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit dummy;
    int n;
    n = 0;
    while ((exp_c_q.size() != 0 || out_valid) && n < 100) begin
      cycle(1'b0, 0, 0, 0, 1'b1, dummy);
      n++;
    end
    chk("drain_left", exp_c_q.size(), 0);
  endtask

  initial begin
    bit acc_ok;
    int k;
    int n;
    int start_cnt;
    int ops6[6];
    int av6[6];
    int bv6[6];
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_c", int'(c), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    // Back-to-back ops with latency probe on the first beat.
    cycle(1'b1, 5, -3, 0, 1'b1, acc_ok);
    chk("lat_edge1_valid", int'(out_valid), 0);
    cycle(1'b1, 5, -3, 1, 1'b1, acc_ok);
    chk("lat_edge2_valid", int'(out_valid), 1);
    chk("first_c", int'(c), 5);
    cycle(1'b1, 5, -3, 2, 1'b1, acc_ok);
    cycle(1'b1, 5, -3, 3, 1'b1, acc_ok);
    cycle(1'b1, 5, -3, 6, 1'b1, acc_ok);
    chk("b2b_in_ready", int'(in_ready), 1);
    cycle(1'b1, 5, -3, 7, 1'b1, acc_ok);
    drain();

    send(-128, 127, 3);
    send(127, 127, 2);
    drain();

    send(0, 0, 5);
    send(10, 0, 4);
    send(1, 1, 2);
    send(-4, 0, 4);
    send(100, 0, 4);
    drain();
    chk("acc_model_106", model_acc, 106);

    // Backpressure: four stalled cycles in the middle of a six-beat stream.
    ops6 = '{4, 2, 4, 0, 7, 4};
    for (int i = 0; i < 6; i++) begin
      av6[i] = int'($urandom_range(0, 255)) - 128;
      bv6[i] = int'($urandom_range(0, 255)) - 128;
    end
    saw_not_ready = 0;
    start_cnt = out_count;
    n = 0; k = 0;
    while (n < 6 && k < 40) begin
      cycle(1'b1, av6[n], bv6[n], ops6[n], !(k >= 2 && k < 6), acc_ok);
      if (acc_ok) n++;
      k++;
    end
    drain();
    chk("bp_in_ready_drop", int'(saw_not_ready), 1);
    chk("bp_beat_count", out_count - start_cnt, 6);

    // Overflow: build acc to 2000, then push past the positive limit.
    send(0, 0, 5);
    for (int i = 0; i < 20; i++) send(100, 0, 4);
    send(100, 0, 4);
    send(100, 0, 4);
    drain();
`ifdef DATA_PROC_SAT_EN
    chk("ovf_model", model_acc, 2047);
`else
    chk("ovf_model", model_acc, -1896);
`endif

    // Random traffic with random backpressure, biased toward accumulate.
    for (int i = 0; i < 400; i++) begin
      int rop;
      rop = ($urandom_range(0, 2) == 0) ? 4 : int'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128, rop, $urandom_range(0, 3) != 0, acc_ok);
    end
    drain();

    // Asynchronous reset between edges with two beats in flight.
    send(0, 0, 5);
    send(50, 0, 4);
    drain();
    cycle(1'b1, 3, 4, 2, 1'b0, acc_ok);
    cycle(1'b1, 7, 1, 0, 1'b0, acc_ok);
    chk("inflight_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_c", int'(c), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    exp_c_q.delete();
    exp_s_q.delete();
    model_acc = 0;
    stall_prev = 0;
    @(negedge clk);
    rst_n = 1'b1;
    start_cnt = out_count;
    send(1, 0, 4);
    drain();
    chk("post_rst_beats", out_count - start_cnt, 1);
    chk("post_rst_acc", model_acc, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
